// File: rtl/cache_pkg.sv
// Shared types for the cache controller / directory pair.
// line_state_t: MESI-style coherence state stored per directory set.
package cache_pkg;

    typedef enum logic [1:0] {
        INVALID   = 2'd0,
        SHARED    = 2'd1,
        EXCLUSIVE = 2'd2,
        MODIFIED  = 2'd3
    } line_state_t;

endpackage

// File: rtl/cache_dir_if.sv
// Lookup/update channel between the cache controller (req) and the
// cache directory (rsp).
//   addr          : line address to look up or write
//   next_state    : state committed on a write
//   write         : commit tag/next_state for addr on the next clock edge
//   current_state : stored state of the addressed set (combinational)
//   hit           : tag matches and the line is valid (combinational)
interface cache_dir_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    import cache_pkg::*;

    logic [ADDR_WIDTH-1:0] addr;
    line_state_t           next_state;
    logic                  write;
    line_state_t           current_state;
    logic                  hit;

    modport req (output addr, next_state, write, input current_state, hit);
    modport rsp (input addr, next_state, write, output current_state, hit);

endinterface

// File: rtl/cache_dir.sv
// Direct-mapped cache directory: one tag and one coherence state per set.
// After reset or flush an internal sweep invalidates every set before
// lookups and writes are served.
//   clk   : clock
//   rst   : synchronous active-high reset
//   dir   : cache_dir_if responder (addr/next_state/write in, current_state/hit out)
//   flush : single-cycle pulse, invalidates all sets
//   ready : registered, high while lookups and writes are served
module cache_dir
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned NUM_SETS   = 64
) (
    input  logic       clk,
    input  logic       rst,
    cache_dir_if.rsp   dir,
    input  logic       flush,
    output logic       ready
);

    localparam int unsigned OFF = $clog2(LINE_BYTES);
    localparam int unsigned IDX = $clog2(NUM_SETS);
    localparam int unsigned TAG = ADDR_WIDTH - IDX - OFF;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } fsm_t;

    fsm_t                 st_q;
    fsm_t                 st_d;
    logic [IDX-1:0]       sweep_q;
    logic [IDX-1:0]       sweep_d;

    logic [TAG-1:0]       tag_q   [NUM_SETS];
    line_state_t          state_q [NUM_SETS];

    logic [IDX-1:0]       idx;
    logic [TAG-1:0]       tag;
    logic                 sweep_we;
    logic                 wr_en;

    // Address split; offset bits never take part in a lookup.
    assign idx = dir.addr[OFF +: IDX];
    assign tag = dir.addr[ADDR_WIDTH-1 -: TAG];

    logic unused_off;
    assign unused_off = ^dir.addr[OFF-1:0];

    // State register, sweep counter and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_INIT;
            sweep_q <= '0;
            ready   <= 1'b0;
        end else begin
            st_q    <= st_d;
            sweep_q <= sweep_d;
            ready   <= (st_d == ST_READY);
        end
    end

    // Next-state: sweep every set once, flush restarts the sweep from set 0.
    always_comb begin
        st_d    = st_q;
        sweep_d = sweep_q;
        case (st_q)
            ST_INIT: begin
                if (flush) begin
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + IDX'(1);
                    if (sweep_q == IDX'(NUM_SETS - 1)) begin
                        st_d = ST_READY;
                    end
                end
            end
            ST_READY: begin
                if (flush) begin
                    st_d    = ST_INIT;
                    sweep_d = '0;
                end
            end
            default: begin
                st_d    = ST_INIT;
                sweep_d = '0;
            end
        endcase
    end

    // Outputs: lookups are masked during the sweep; a flush or reset in the
    // same cycle drops a controller write.
    always_comb begin
        sweep_we          = 1'b0;
        wr_en             = 1'b0;
        dir.hit           = 1'b0;
        dir.current_state = INVALID;
        if (st_q == ST_INIT) begin
            sweep_we = 1'b1;
        end else begin
            dir.current_state = state_q[idx];
            dir.hit           = (tag_q[idx] == tag) && (state_q[idx] != INVALID);
            wr_en             = dir.write && !flush && !rst;
        end
    end

    // Directory storage; tags are never cleared, only states.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            state_q[sweep_q] <= INVALID;
        end else if (wr_en) begin
            tag_q[idx]   <= tag;
            state_q[idx] <= dir.next_state;
        end
    end

endmodule
